// File: rtl/lsu_ctrl.sv
// Load/store unit controller: core request -> one or two aligned bus beats -> response.
// Optional macro LSU_MISALIGN_SPLIT_EN enables splitting of accesses that cross an NB-byte word.
module lsu_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [XLEN-1:0]   resp_rdata,
  input  logic              resp_ack,
  output logic [31:0]       Address,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [XLEN-1:0]   Write_data,
  output logic [XLEN/8-1:0] Write_strb,
  input  logic              Mem_Req_Ack,
  input  logic [XLEN-1:0]   Read_data,
  input  logic              Read_data_Valid,
  output logic              Read_data_Ack
);

  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned LB  = $clog2(NB);
  localparam int unsigned NB2 = 2 * NB;
  localparam int unsigned XL2 = 2 * XLEN;

  typedef enum logic [2:0] {IDLE, REQ1, RDW1, REQ2, RDW2, RESP} state_t;

  state_t            state, state_nx;
  logic              we_q;
  logic [2:0]        op_q;
  logic [31:0]       addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              err_q;
  logic [XLEN-1:0]   rd1_q, rd2_q;
  logic              req_illegal;

`ifndef LSU_MISALIGN_SPLIT_EN
  logic [LB-1:0]     req_off;
  logic [3:0]        req_size_m1;
  assign req_off     = req_addr[LB-1:0];
  assign req_size_m1 = (4'd1 << req_op[1:0]) - 4'd1;
`endif

  always_comb begin
    req_illegal = 1'b0;
    if (req_op == 3'b111) req_illegal = 1'b1;
    if (XLEN == 32 && (req_op == 3'b011 || req_op == 3'b110)) req_illegal = 1'b1;
    if (req_we && (req_op == 3'b011 || req_op == 3'b110)) req_illegal = 1'b1;
`ifndef LSU_MISALIGN_SPLIT_EN
    if ((4'(req_off) & req_size_m1) != 4'd0) req_illegal = 1'b1;
`endif
  end

  // Geometry of the latched access
  logic [LB-1:0]   off;
  logic [3:0]      size;
  logic            split;
  logic [31:0]     base;
  logic [NB2-1:0]  bmask;
  logic [XLEN-1:0] wdata_m;
  logic [XL2-1:0]  wide;

  assign off  = addr_q[LB-1:0];
  assign size = 4'd1 << op_q[1:0];
  assign base = {addr_q[31:LB], {LB{1'b0}}};
`ifdef LSU_MISALIGN_SPLIT_EN
  assign split = (5'(off) + 5'(size)) > 5'(NB);
`else
  assign split = 1'b0;
`endif

  // Byte enables and data laid out across two consecutive words; upper half is beat 2
  assign bmask = ((NB2'(1) << size) - NB2'(1)) << off;

  always_comb begin
    wdata_m = '0;
    for (int unsigned i = 0; i < NB; i++)
      if (i < 32'(size)) wdata_m[8*i +: 8] = wdata_q[8*i +: 8];
  end

  assign wide = {{XLEN{1'b0}}, wdata_m} << {off, 3'b000};

  // Load result: concatenated beats shifted down by the offset, then extended
  logic [XLEN-1:0] ld_raw, ld_res;
  logic            ld_sign;

  assign ld_raw = XLEN'({rd2_q, rd1_q} >> {off, 3'b000});

  always_comb begin
    ld_res = '0;
    case (op_q[1:0])
      2'b00:   ld_sign = ld_raw[7];
      2'b01:   ld_sign = ld_raw[15];
      2'b10:   ld_sign = ld_raw[31];
      default: ld_sign = ld_raw[XLEN-1];
    endcase
    for (int unsigned i = 0; i < NB; i++)
      ld_res[8*i +: 8] = (i < 32'(size)) ? ld_raw[8*i +: 8] : {8{ld_sign & ~op_q[2]}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_illegal;
        rd2_q   <= '0;
      end
      if (state == RDW1 && Read_data_Valid) rd1_q <= Read_data;
      if (state == RDW2 && Read_data_Valid) rd2_q <= Read_data;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = req_illegal ? RESP : REQ1;
      REQ1: if (Mem_Req_Ack) state_nx = !we_q ? RDW1 : (split ? REQ2 : RESP);
      RDW1: if (Read_data_Valid) state_nx = split ? REQ2 : RESP;
      REQ2: if (Mem_Req_Ack) state_nx = we_q ? RESP : RDW2;
      RDW2: if (Read_data_Valid) state_nx = RESP;
      RESP: if (resp_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == IDLE);
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    Address       = '0;
    Write_data    = '0;
    Write_strb    = '0;
    Read_data_Ack = 1'b0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    resp_rdata    = '0;
    case (state)
      REQ1: begin
        MemRead  = ~we_q;
        MemWrite = we_q;
        Address  = base;
        if (we_q) begin
          Write_data = wide[XLEN-1:0];
          Write_strb = bmask[NB-1:0];
        end
      end
      REQ2: begin
        MemRead  = ~we_q;
        MemWrite = we_q;
        Address  = base + 32'(NB);
        if (we_q) begin
          Write_data = wide[XL2-1:XLEN];
          Write_strb = bmask[NB2-1:NB];
        end
      end
      RDW1, RDW2: Read_data_Ack = 1'b1;
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !we_q) resp_rdata = ld_res;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl (XLEN=32): directed cases plus randomized traffic
// against a byte-level reference model with a randomly stalling bus and core.
module tb_lsu_ctrl;

  localparam int XLEN = 32;
  localparam int NB   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, resp_ack;
  logic [31:0] resp_rdata;
  logic [31:0] Address;
  logic        MemRead, MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ack;
  logic [31:0] Read_data;
  logic        Read_data_Valid, Read_data_Ack;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata), .resp_ack(resp_ack),
    .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ack(Mem_Req_Ack),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference: legality from the opcode/alignment rules
  function automatic bit mdl_illegal(input logic we, input logic [2:0] op, input logic [31:0] addr);
    int unsigned size = 1 << op[1:0];
    int unsigned off  = addr % NB;
    if (op == 3'b111) return 1'b1;
    if (op == 3'b011 || op == 3'b110) return 1'b1;
    if (we && (op == 3'b011 || op == 3'b110)) return 1'b1;
`ifndef LSU_MISALIGN_SPLIT_EN
    if (off % size != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; Mem_Req_Ack = 1'b0; Read_data_Valid = 1'b0; resp_ack = 1'b0;
    Read_data = $urandom;
  endtask

  // One transaction; waits < 0 are drawn at random per beat. Called at #1 after a posedge.
  task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdv0, input logic [31:0] rdv1,
                         input int ack_wait, input int val_wait, input int rack_wait,
                         input bit chk_const, input logic [31:0] exp_const);
    bit          err;
    int unsigned size, off, nb, bi, ri, cyc, a_cnt, v_cnt, r_cnt, a_w, v_w, r_w;
    logic [31:0] base;
    logic [31:0] e_data [2];
    logic [3:0]  e_strb [2];
    logic [31:0] rd [2];
    logic [31:0] e_res;
    bit          seen_resp, done, stalled, a_sent, v_sent, r_sent;

    err  = mdl_illegal(we, op, addr);
    size = 1 << op[1:0];
    off  = addr % NB;
    nb   = err ? 0 : ((off + size > NB) ? 2 : 1);
    base = addr & ~32'(NB - 1);
    rd[0] = rdv0; rd[1] = rdv1;
    for (int b = 0; b < 2; b++) begin e_data[b] = '0; e_strb[b] = '0; end
    if (we && !err)
      for (int unsigned k = 0; k < size; k++) begin
        e_strb[(off + k) / NB][(off + k) % NB] = 1'b1;
        e_data[(off + k) / NB][8*((off + k) % NB) +: 8] = wdata[8*k +: 8];
      end

    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_op = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    bi = 0; ri = 0; cyc = 0; a_cnt = 0; v_cnt = 0; r_cnt = 0;
    a_w = (ack_wait < 0) ? $urandom_range(0, 3) : ack_wait;
    v_w = (val_wait < 0) ? $urandom_range(0, 3) : val_wait;
    r_w = (rack_wait < 0) ? $urandom_range(0, 3) : rack_wait;
    seen_resp = 0; done = 0; stalled = 0;

    while (!done && !stalled && cyc < 200) begin
      cyc++;
      Mem_Req_Ack = 1'b0; Read_data_Valid = 1'b0; resp_ack = 1'b0;
      a_sent = 0; v_sent = 0; r_sent = 0;
      check("req_ready_busy", req_ready, 0);
      if (resp_valid) begin
        if (!seen_resp) begin
          seen_resp = 1;
          e_res = '0;
          if (!we && !err) begin
            for (int unsigned k = 0; k < size; k++)
              e_res[8*k +: 8] = rd[(off + k) / NB][8*((off + k) % NB) +: 8];
            if (!op[2] && e_res[8*size - 1])
              for (int unsigned k = size; k < NB; k++) e_res[8*k +: 8] = 8'hFF;
          end
          check("resp_err", resp_err, err);
          check("resp_rdata", resp_rdata, e_res);
          check("beats_issued", bi, nb);
          if (chk_const) check("resp_known", err ? 32'hEEEE_EEEE : resp_rdata, exp_const);
          if (ack_wait == 0 && val_wait == 0)
            check("latency", cyc, err ? 1 : (we ? 1 + nb : 1 + 2 * nb));
        end else begin
          check("resp_err_held", resp_err, err);
          check("resp_rdata_held", resp_rdata, e_res);
        end
        if (r_cnt >= r_w) begin resp_ack = 1'b1; r_sent = 1; end else r_cnt++;
      end else if (MemRead || MemWrite) begin
        check("bus_beat_expected", 32'(bi < nb), 1);
        if (bi < nb) begin
          check("Address", Address, base + 32'(NB * bi));
          check("MemRead", MemRead, !we);
          check("MemWrite", MemWrite, we);
          check("Write_data", Write_data, e_data[bi]);
          check("Write_strb", Write_strb, e_strb[bi]);
        end
        if (a_cnt >= a_w) begin Mem_Req_Ack = 1'b1; a_sent = 1; end else a_cnt++;
      end else if (Read_data_Ack) begin
        check("read_phase_expected", 32'(!we && ri < bi && ri < nb), 1);
        if (v_cnt >= v_w) begin
          Read_data_Valid = 1'b1; Read_data = rd[ri % 2]; v_sent = 1;
        end else begin
          v_cnt++; Read_data = $urandom;
        end
      end else begin
        check("fsm_active", 0, 1);
        stalled = 1;
      end
      if (!stalled) begin
        @(posedge clk); #1;
        if (a_sent) begin bi++; a_cnt = 0; a_w = (ack_wait < 0) ? $urandom_range(0, 3) : ack_wait; end
        if (v_sent) begin ri++; v_cnt = 0; v_w = (val_wait < 0) ? $urandom_range(0, 3) : val_wait; end
        if (r_sent) done = 1;
      end
    end
    if (!done) check("txn_complete", 0, 1);
    idle_inputs();
    check("req_ready_after", req_ready, 1);
    check("resp_valid_after", resp_valid, 0);
  endtask

  task automatic reset_mid_read();
    int unsigned n;
    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h200; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!Read_data_Ack && n < 20) begin
      Mem_Req_Ack = MemRead;
      @(posedge clk); #1;
      n++;
    end
    Mem_Req_Ack = 1'b0;
    check("reached_rdw1", Read_data_Ack, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_rdack", Read_data_Ack, 0);
    check("rst_ready", req_ready, 1);
    check("rst_resp", resp_valid, 0);
    check("rst_memread", MemRead, 0);
    Read_data_Valid = 1'b1; Read_data = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("late_beat_no_resp", resp_valid, 0);
      check("late_beat_ready", req_ready, 1);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; req_we = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_MemRead", MemRead, 0);
    check("rst_MemWrite", MemWrite, 0);
    check("rst_Read_data_Ack", Read_data_Ack, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_Write_strb", Write_strb, 0);
    check("rst_Address", Address, 0);
    check("rst_Write_data", Write_data, 0);
    check("rst_resp_rdata", resp_rdata, 0);

    // sw 0x100, zero-wait bus and core
    run_txn(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 32'h0);
    // lb / lbu 0x103
    run_txn(0, 3'b000, 32'h103, 0, 32'h80112233, 0, 0, 0, 0, 1, 32'hFFFFFF80);
    run_txn(0, 3'b100, 32'h103, 0, 32'h80112233, 0, 0, 0, 0, 1, 32'h00000080);
`ifdef LSU_MISALIGN_SPLIT_EN
    run_txn(0, 3'b010, 32'h102, 0, 32'h11223344, 32'h55667788, 0, 0, 0, 1, 32'h77881122);
`else
    run_txn(0, 3'b010, 32'h102, 0, 32'h11223344, 32'h55667788, 0, 0, 0, 1, 32'hEEEE_EEEE);
`endif
    run_txn(1, 3'b001, 32'h103, 32'h0000ABCD, 0, 0, 0, 0, 0, 0, 0);
    // illegal ops
    run_txn(0, 3'b111, 32'h40, 0, 0, 0, 0, 0, 0, 1, 32'hEEEE_EEEE);
    run_txn(1, 3'b011, 32'h40, 0, 0, 0, 0, 0, 0, 1, 32'hEEEE_EEEE);
    run_txn(0, 3'b110, 32'h40, 0, 0, 0, 0, 0, 0, 1, 32'hEEEE_EEEE);
    // stalled bus and core, plus the top-of-memory boundary
    run_txn(0, 3'b010, 32'h300, 0, 32'h13572468, 0, 3, 0, 2, 1, 32'h13572468);
    run_txn(0, 3'b101, 32'hFFFF_FFFF, 0, 32'hA5000000, 32'h0000005A, 0, 0, 0, 0, 0);
    run_txn(1, 3'b010, 32'hFFFF_FFFE, 32'h89ABCDEF, 0, 0, 0, 0, 0, 0, 0);

    reset_mid_read();
    run_txn(0, 3'b001, 32'h202, 0, 32'h8001_7FFF, 0, 0, 0, 0, 1, 32'hFFFF8001);

    for (int t = 0; t < 300; t++) begin
      bit zw;
      zw = ($urandom_range(0, 3) == 0);
      run_txn(1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom, $urandom, $urandom,
              zw ? 0 : -1, zw ? 0 : -1, zw ? 0 : -1, 0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
